head_assembler: RTL and testbench
=================================

HEAD_ASSEMBLER -- requirements
Module: head_assembler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, giving the input beat width in bits.
REQ-002 The block SHALL have parameter HEAD_WIDTH, default 1024, giving the head width delivered to the first Parser_Layer; it SHALL be an integer multiple of DATA_WIDTH.
REQ-003 The block SHALL derive HEAD_BEATS = HEAD_WIDTH/DATA_WIDTH, with a legal range of 1..255.
REQ-004 The block SHALL have port i_clk, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_data_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have port i_data_sop, input, 1 bit: first beat of a packet.
REQ-008 The block SHALL have port i_data_eop, input, 1 bit: last beat of a packet.
REQ-009 The block SHALL have port i_data, input, DATA_WIDTH bits: beat payload, first wire byte in the MSBs.
REQ-010 The block SHALL have port o_data_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-011 The block SHALL have port o_head_valid, output, 1 bit: single-cycle strobe feeding i_head_valid of the parser.
REQ-012 The block SHALL have port o_head, output, HEAD_WIDTH bits: assembled head feeding i_head of the parser.
REQ-013 The block SHALL have port o_head_beats, output, 8 bits: number of beats captured into o_head.
REQ-014 The block SHALL have port o_err_cnt, output, 16 bits: framing-error counter.

Function
REQ-015 A beat SHALL be accepted only in a cycle where i_data_valid=1 and o_data_ready=1.
REQ-016 The FSM SHALL have four states: IDLE, COLLECT, EMIT and DRAIN.
REQ-017 o_data_ready SHALL be 1 in IDLE, COLLECT and DRAIN, and 0 in EMIT.
REQ-018 In IDLE, an accepted beat with sop=1 SHALL be written to head slot 0 (o_head MSBs), SHALL clear all other slots to zero, and SHALL set the beat count to 1.
REQ-019 In IDLE, an accepted beat with sop=0 SHALL be discarded.
REQ-020 From IDLE, the FSM SHALL go to EMIT if the sop beat also has eop=1 or HEAD_BEATS=1; otherwise it SHALL go to COLLECT.
REQ-021 In COLLECT, accepted beat k SHALL be written to slot k, and the beat count SHALL increment.
REQ-022 From COLLECT, the FSM SHALL go to EMIT when the beat has eop=1 or the count reaches HEAD_BEATS.
REQ-023 In EMIT, o_head_valid SHALL be 1 for exactly one cycle, with o_head and o_head_beats stable in that cycle.
REQ-024 The head strobe latency SHALL be exactly one cycle after the completing beat is accepted.
REQ-025 From EMIT, the FSM SHALL go to DRAIN if the completing beat had eop=0, and to IDLE otherwise.
REQ-026 In DRAIN, accepted beats SHALL be discarded, and an eop=1 beat SHALL return the FSM to IDLE.
REQ-027 Unused head slots SHALL read zero; o_head SHALL hold its value outside EMIT.
REQ-028 o_err_cnt SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-029 o_head_beats SHALL never exceed HEAD_BEATS.

Reset
REQ-030 While i_rst=1, the FSM SHALL be forced to IDLE with the beat count at 0 and the outputs at: o_head=0, o_head_beats=0, o_head_valid=0, o_err_cnt=0, o_data_ready=0.
REQ-031 o_data_ready SHALL return to 1 on the first clock edge after i_rst is released.
REQ-032 Assertion of i_rst during COLLECT, EMIT or DRAIN SHALL abort the packet with no head strobe, and the next accepted beat SHALL be treated as in IDLE.

Configuration
REQ-033 Macro HEAD_ASM_ERR_CHK_EN SHALL control framing-error checking.
REQ-034 With HEAD_ASM_ERR_CHK_EN defined, each of the following SHALL increment o_err_cnt by 1: a beat discarded in IDLE for sop=0, and a beat with sop=1 in COLLECT or DRAIN.
REQ-035 With HEAD_ASM_ERR_CHK_EN defined, a sop=1 beat in COLLECT SHALL abandon the current head without a strobe and SHALL restart capture as in IDLE, in the same cycle.
REQ-036 With HEAD_ASM_ERR_CHK_EN defined, a sop=1 beat in DRAIN SHALL restart capture as in IDLE, in the same cycle.
REQ-037 Without HEAD_ASM_ERR_CHK_EN, sop SHALL be ignored outside IDLE, no restart SHALL occur, and o_err_cnt SHALL be tied to 0.

Verification (DATA_WIDTH=128, HEAD_WIDTH=512, HEAD_BEATS=4)
REQ-038 Scenario: a 6-beat packet with beats B0..B5 = 0x11..1, 0x22..2, ..., 0x66..6 -> one o_head_valid strobe one cycle after B3; o_head={B0,B1,B2,B3}; o_head_beats=4; o_data_ready=0 for that one cycle; B4 and B5 dropped; FSM back in IDLE after B5.
REQ-039 Scenario: a 1-beat packet (sop=eop=1, data 0xAB..AB) -> strobe on the next cycle; o_head={0xAB..AB, 0, 0, 0}; o_head_beats=1.
REQ-040 Scenario: a 2-beat packet followed immediately by a 4-beat packet, back-to-back with i_data_valid held at 1 -> two strobes with o_head_beats=2, then 4; the beat presented during EMIT is not accepted and is held by the source; no beat is lost or duplicated.
REQ-041 Scenario: i_rst pulsed after the 2nd beat of a 4-beat packet, then a fresh 3-beat packet -> no strobe for the aborted packet; exactly one strobe for the fresh packet, with o_head_beats=3.
REQ-042 Scenario with HEAD_ASM_ERR_CHK_EN defined: a sop=0 beat in IDLE, then a sop beat, then a second sop beat at beat 2 -> o_err_cnt=2; the head contains data from the second packet only.
REQ-043 Scenario without HEAD_ASM_ERR_CHK_EN: the same stimulus as REQ-042 -> o_err_cnt=0; the second sop beat is stored as data in slot 1.

Source files
------------

// File: rtl/head_assembler.sv
// head_assembler: collects the first HEAD_WIDTH bits of each packet from a
// DATA_WIDTH beat stream and presents them to the parser as one wide head.
// Optional framing-error checking is enabled by defining HEAD_ASM_ERR_CHK_EN.
module head_assembler #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned HEAD_WIDTH = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data_valid,
    input  logic                  i_data_sop,
    input  logic                  i_data_eop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_data_ready,
    output logic                  o_head_valid,
    output logic [HEAD_WIDTH-1:0] o_head,
    output logic [7:0]            o_head_beats,
    output logic [15:0]           o_err_cnt
);

    localparam int unsigned HEAD_BEATS   = HEAD_WIDTH / DATA_WIDTH;
    localparam logic [7:0]  HEAD_BEATS_B = 8'(HEAD_BEATS);

`ifdef HEAD_ASM_ERR_CHK_EN
    localparam bit ERR_CHK = 1'b1;
`else
    localparam bit ERR_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT,
        DRAIN
    } state_e;

    state_e                  state_q, state_d;
    logic [HEAD_WIDTH-1:0]   buf_q, buf_d;
    logic [HEAD_WIDTH-1:0]   head_q, head_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              beats_q, beats_d;
    logic                    eop_q, eop_d;
    logic                    ready_q, ready_d;
    logic [15:0]             err_q, err_d;
    logic                    accept;
    logic                    start;
    logic                    err_inc;

    // State, staging buffer, output head and error counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            head_q  <= '0;
            cnt_q   <= '0;
            beats_q <= '0;
            eop_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            eop_q   <= eop_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Next-state, slot capture and error detection
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        head_d  = head_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        eop_d   = eop_q;
        start   = 1'b0;
        err_inc = 1'b0;
        accept  = i_data_valid && ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_data_sop) start = 1'b1;
                    else            err_inc = ERR_CHK;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (ERR_CHK && i_data_sop) begin
                        err_inc = 1'b1;
                        start   = 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < HEAD_BEATS; k++) begin
                            if (8'(k) == cnt_q)
                                buf_d[HEAD_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH] = i_data;
                        end
                        cnt_d = cnt_q + 8'd1;
                        if (i_data_eop || cnt_d == HEAD_BEATS_B) begin
                            state_d = EMIT;
                            eop_d   = i_data_eop;
                        end
                    end
                end
            end
            EMIT: begin
                state_d = eop_q ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (accept) begin
                    if (ERR_CHK && i_data_sop) begin
                        err_inc = 1'b1;
                        start   = 1'b1;
                    end else if (i_data_eop) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared capture start: sop beat in IDLE, or a restart on a stray sop
        if (start) begin
            buf_d = '0;
            buf_d[HEAD_WIDTH-1 -: DATA_WIDTH] = i_data;
            cnt_d = 8'd1;
            if (i_data_eop || HEAD_BEATS == 1) begin
                state_d = EMIT;
                eop_d   = i_data_eop;
            end else begin
                state_d = COLLECT;
            end
        end

        // o_head is a separate register loaded only on completion, so it keeps
        // the previous head while the next one is being staged in buf_q
        if (state_d == EMIT) begin
            head_d  = buf_d;
            beats_d = cnt_d;
        end

        ready_d = (state_d != EMIT);
        err_d   = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    assign o_data_ready = ready_q;
    assign o_head_valid = (state_q == EMIT);
    assign o_head       = head_q;
    assign o_head_beats = beats_q;
    assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_head_assembler.sv
// Randomized and directed bench for head_assembler against a packet-level
// reference model (queue of captured beats, packed into a head on completion).
module tb_head_assembler;

    localparam int unsigned DW = 128;
    localparam int unsigned HW = 512;
    localparam int unsigned HB = HW / DW;

`ifdef HEAD_ASM_ERR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic          i_clk;
    logic          i_rst;
    logic          i_data_valid;
    logic          i_data_sop;
    logic          i_data_eop;
    logic [DW-1:0] i_data;
    logic          o_data_ready;
    logic          o_head_valid;
    logic [HW-1:0] o_head;
    logic [7:0]    o_head_beats;
    logic [15:0]   o_err_cnt;

    head_assembler #(
        .DATA_WIDTH(DW),
        .HEAD_WIDTH(HW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data_valid (i_data_valid),
        .i_data_sop   (i_data_sop),
        .i_data_eop   (i_data_eop),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_head_valid (o_head_valid),
        .o_head       (o_head),
        .o_head_beats (o_head_beats),
        .o_err_cnt    (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source stream and bubble rate
    beat_t src_q[$];
    int    bubble_pct = 0;

    // Reference model: mode 0 = waiting for sop, 1 = collecting, 2 = dropping
    logic [DW-1:0] m_q[$];
    int            m_mode;
    bit            m_emit;
    bit            m_last_eop;
    bit            m_rdy_en;
    logic [HW-1:0] m_last_head;
    logic [7:0]    m_last_beats;
    logic [15:0]   m_err;

    // Observed strobes for directed scenarios
    int            n_strobes;
    logic [HW-1:0] obs_head;
    logic [7:0]    obs_beats[$];

    task automatic check_eq(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic logic [HW-1:0] pack_head();
        logic [HW-1:0] h;
        h = '0;
        for (int i = 0; i < m_q.size(); i++)
            h = h | ({m_q[i], {(HW-DW){1'b0}}} >> (i * DW));
        return h;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_mode       = 0;
        m_emit       = 1'b0;
        m_last_eop   = 1'b0;
        m_rdy_en     = 1'b0;
        m_last_head  = '0;
        m_last_beats = '0;
        m_err        = '0;
    endtask

    task automatic model_err();
        if (CHK && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    endtask

    task automatic model_complete(input bit e);
        m_emit       = 1'b1;
        m_last_head  = pack_head();
        m_last_beats = 8'(m_q.size());
        m_last_eop   = e;
        m_mode       = 0;
    endtask

    task automatic model_start(input beat_t b);
        m_q.delete();
        m_q.push_back(b.data);
        if (b.eop || HB == 1) model_complete(b.eop);
        else                  m_mode = 1;
    endtask

    task automatic model_step(input bit acc, input beat_t b);
        if (m_emit) begin
            m_emit = 1'b0;
            m_mode = m_last_eop ? 0 : 2;
        end else if (acc) begin
            case (m_mode)
                0: if (b.sop) model_start(b); else model_err();
                1: begin
                    if (CHK && b.sop) begin
                        model_err();
                        model_start(b);
                    end else begin
                        m_q.push_back(b.data);
                        if (b.eop || m_q.size() == HB) model_complete(b.eop);
                    end
                end
                default: begin
                    if (CHK && b.sop) begin
                        model_err();
                        model_start(b);
                    end else if (b.eop) begin
                        m_mode = 0;
                    end
                end
            endcase
        end
        m_rdy_en = 1'b1;
    endtask

    task automatic push_beat(input bit s, input bit e, input logic [DW-1:0] d);
        beat_t b;
        b.sop  = s;
        b.eop  = e;
        b.data = d;
        src_q.push_back(b);
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model
    task automatic run_cycle();
        beat_t b;
        bit    drive;
        bit    acc;
        b     = '0;
        drive = (src_q.size() > 0) && (int'($urandom_range(99)) >= bubble_pct);
        if (drive) begin
            b            = src_q[0];
            i_data_valid = 1'b1;
            i_data_sop   = b.sop;
            i_data_eop   = b.eop;
            i_data       = b.data;
        end else begin
            i_data_valid = 1'b0;
            i_data_sop   = 1'($urandom_range(1));
            i_data_eop   = 1'($urandom_range(1));
            i_data       = {$urandom, $urandom, $urandom, $urandom};
        end
        if (i_rst) model_reset();
        @(negedge i_clk);
        check_eq("ready", HW'(o_data_ready), HW'(m_rdy_en && !m_emit));
        check_eq("head_valid", HW'(o_head_valid), HW'(m_emit));
        check_eq("head", o_head, m_last_head);
        check_eq("head_beats", HW'(o_head_beats), HW'(m_last_beats));
        check_eq("err_cnt", HW'(o_err_cnt), HW'(m_err));
        if (o_head_valid === 1'b1) begin
            n_strobes++;
            obs_head = o_head;
            obs_beats.push_back(o_head_beats);
        end
        acc = drive && m_rdy_en && !m_emit && !i_rst;
        if (acc) void'(src_q.pop_front());
        if (!i_rst) model_step(acc, b);
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_until_empty(input int bound);
        int cyc;
        cyc = 0;
        while (src_q.size() > 0 && cyc < bound) begin
            run_cycle();
            cyc++;
        end
        if (src_q.size() != 0) check_eq("src_drain_timeout", HW'(src_q.size()), '0);
        repeat (4) run_cycle();
    endtask

    task automatic clear_obs();
        n_strobes = 0;
        obs_head  = '0;
        obs_beats.delete();
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        run_cycle();
        run_cycle();
        i_rst = 1'b0;
    endtask

    initial begin
        int unsigned len;
        i_rst        = 1'b1;
        i_data_valid = 1'b0;
        i_data_sop   = 1'b0;
        i_data_eop   = 1'b0;
        i_data       = '0;
        model_reset();
        clear_obs();
        repeat (2) @(posedge i_clk);
        #1;
        run_cycle();
        i_rst = 1'b0;
        run_cycle();

        // 6-beat packet: head from first four beats, last two dropped
        bubble_pct = 0;
        clear_obs();
        for (int unsigned k = 1; k <= 6; k++)
            push_beat(k == 1, k == 6, rep(8'(k * 17)));
        run_until_empty(100);
        check_eq("s6_strobes", HW'(n_strobes), HW'(1));
        check_eq("s6_head", obs_head, {rep(8'h11), rep(8'h22), rep(8'h33), rep(8'h44)});
        check_eq("s6_beats", HW'(obs_beats.size() > 0 ? obs_beats[0] : 8'hFF), HW'(4));

        // single-beat packet
        clear_obs();
        push_beat(1'b1, 1'b1, rep(8'hAB));
        run_until_empty(100);
        check_eq("s1_strobes", HW'(n_strobes), HW'(1));
        check_eq("s1_head", obs_head, {rep(8'hAB), {(HW-DW){1'b0}}});
        check_eq("s1_beats", HW'(obs_beats.size() > 0 ? obs_beats[0] : 8'hFF), HW'(1));

        // back-to-back 2-beat then 4-beat packets
        clear_obs();
        push_beat(1'b1, 1'b0, rep(8'hC0));
        push_beat(1'b0, 1'b1, rep(8'hC1));
        for (int unsigned k = 0; k < 4; k++)
            push_beat(k == 0, k == 3, rep(8'(8'hD0 + k)));
        run_until_empty(100);
        check_eq("b2b_strobes", HW'(n_strobes), HW'(2));
        check_eq("b2b_beats0", HW'(obs_beats.size() > 0 ? obs_beats[0] : 8'hFF), HW'(2));
        check_eq("b2b_beats1", HW'(obs_beats.size() > 1 ? obs_beats[1] : 8'hFF), HW'(4));
        check_eq("b2b_head1", obs_head, {rep(8'hD0), rep(8'hD1), rep(8'hD2), rep(8'hD3)});

        // reset mid-packet, then a fresh 3-beat packet
        clear_obs();
        push_beat(1'b1, 1'b0, rep(8'hE0));
        push_beat(1'b0, 1'b0, rep(8'hE1));
        run_until_empty(100);
        pulse_reset();
        push_beat(1'b1, 1'b0, rep(8'hF0));
        push_beat(1'b0, 1'b0, rep(8'hF1));
        push_beat(1'b0, 1'b1, rep(8'hF2));
        run_until_empty(100);
        check_eq("rst_strobes", HW'(n_strobes), HW'(1));
        check_eq("rst_beats", HW'(obs_beats.size() > 0 ? obs_beats[0] : 8'hFF), HW'(3));
        check_eq("rst_head", obs_head, {rep(8'hF0), rep(8'hF1), rep(8'hF2), {DW{1'b0}}});

        // framing: stray beat in idle, then a sop arriving at beat 2
        pulse_reset();
        clear_obs();
        push_beat(1'b0, 1'b0, rep(8'hEE));
        push_beat(1'b1, 1'b0, rep(8'hA1));
        push_beat(1'b1, 1'b0, rep(8'hB1));
        push_beat(1'b0, 1'b0, rep(8'hB2));
        push_beat(1'b0, 1'b1, rep(8'hB3));
        run_until_empty(100);
        check_eq("frm_strobes", HW'(n_strobes), HW'(1));
        check_eq("frm_err_cnt", HW'(o_err_cnt), CHK ? HW'(2) : HW'(0));
        check_eq("frm_beats", HW'(obs_beats.size() > 0 ? obs_beats[0] : 8'hFF), CHK ? HW'(3) : HW'(4));
        check_eq("frm_head", obs_head,
                 CHK ? {rep(8'hB1), rep(8'hB2), rep(8'hB3), {DW{1'b0}}}
                     : {rep(8'hA1), rep(8'hB1), rep(8'hB2), rep(8'hB3)});

        // random traffic with bubbles, stray beats and misplaced sops
        bubble_pct = 25;
        for (int p = 0; p < 80; p++) begin
            len = $urandom_range(1, 7);
            if ($urandom_range(9) == 0)
                push_beat(1'b0, 1'($urandom_range(1)), {$urandom, $urandom, $urandom, $urandom});
            for (int unsigned i = 0; i < len; i++)
                push_beat(i == 0 || $urandom_range(11) == 0, i == len - 1,
                          {$urandom, $urandom, $urandom, $urandom});
        end
        run_until_empty(5000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
